// File: rtl/hdmi_text_pkg.sv
// Shared definitions for the HDMI text controller pixel path.
// Holds the default 640x480@60 raster timing, strobe bundle and text geometry.
package hdmi_text_pkg;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;

   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;

   localparam int unsigned TEXT_COLS = 80;
   localparam int unsigned TEXT_ROWS = 30;
   localparam int unsigned GLYPH_W   = 8;
   localparam int unsigned GLYPH_H   = 16;

   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
   } vga_timing_t;

   // 11-bit compare so a span ending exactly at 1024 does not wrap
   function automatic logic in_span(
      input logic [10:0] v,
      input logic [10:0] lo,
      input logic [10:0] hi
   );
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/strobe_delay.sv
// N-stage shift line for the raster strobe bundle.
// Every stage resets to the supplied idle value; N=0 is a wire.
module strobe_delay #(
   parameter int unsigned N = 2,
   parameter int unsigned W = 3
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [W-1:0] rst_val_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   if (N == 0) begin : g_pass
      logic unused_pass;
      assign unused_pass = ^{clk_i, rst_ni, rst_val_i};
      assign q_o = d_i;
   end else begin : g_sr
      logic [W-1:0] sr_q [N];

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int i = 0; i < int'(N); i++) begin
               sr_q[i] <= rst_val_i;
            end
         end else begin
            sr_q[0] <= d_i;
            for (int i = 1; i < int'(N); i++) begin
               sr_q[i] <= sr_q[i-1];
            end
         end
      end

      assign q_o = sr_q[N-1];
   end

endmodule

// File: rtl/vga_text_timing.sv
// Raster timing generator: drawX/drawY counters, pipelined sync/DE strobes,
// frame-start pulse and blink square wave for the text decoder.
module vga_text_timing
   import hdmi_text_pkg::*;
#(
   parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
   parameter int unsigned H_FP       = DEF_H_FP,
   parameter int unsigned H_SYNC     = DEF_H_SYNC,
   parameter int unsigned H_BP       = DEF_H_BP,
   parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
   parameter int unsigned V_FP       = DEF_V_FP,
   parameter int unsigned V_SYNC     = DEF_V_SYNC,
   parameter int unsigned V_BP       = DEF_V_BP,
   parameter logic        SYNC_POL   = 1'b0,
   parameter int unsigned PIPE_DLY   = 2,
   parameter int unsigned BLINK_LOG2 = 5
) (
   input  logic       pixel_clk,
   input  logic       aresetn,
   output logic [9:0] drawX,
   output logic [9:0] drawY,
   output logic       hsync,
   output logic       vsync,
   output logic       de,
   output logic       frame_start,
   output logic       blink
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_text_timing: H_TOTAL/V_TOTAL exceed 10-bit counters");
   end
   if (PIPE_DLY > 4) begin : g_bad_dly
      $error("vga_text_timing: PIPE_DLY out of range 0..4");
   end

   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
   localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
   localparam logic [10:0] HS_ON    = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_OFF   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_ON    = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_OFF   = 11'(V_ACTIVE + V_FP + V_SYNC);

   localparam vga_timing_t IDLE = '{
      hs: ~SYNC_POL,
      vs: ~SYNC_POL,
      de: 1'b0
   };

   logic [9:0] x_q, x_d;
   logic [9:0] y_q, y_d;
   logic       line_end;
   logic       frame_end;

   always_comb begin
      line_end  = (x_q == H_LAST);
      frame_end = line_end && (y_q == V_LAST);
      x_d       = x_q + 10'd1;
      y_d       = y_q;
      if (line_end) begin
         x_d = '0;
         y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
      end
   end

   always_ff @(posedge pixel_clk or negedge aresetn) begin
      if (!aresetn) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   vga_timing_t strb_d, strb_q, strb_dly;
   logic        hs_raw, vs_raw, vis_raw;

   always_comb begin
      vis_raw   = in_span({1'b0, x_q}, 11'd0, H_VIS) &&
                  in_span({1'b0, y_q}, 11'd0, V_VIS);
      hs_raw    = in_span({1'b0, x_q}, HS_ON, HS_OFF);
      vs_raw    = in_span({1'b0, y_q}, VS_ON, VS_OFF);
      strb_d.hs = hs_raw ? SYNC_POL : ~SYNC_POL;
      strb_d.vs = vs_raw ? SYNC_POL : ~SYNC_POL;
      strb_d.de = vis_raw;
   end

   always_ff @(posedge pixel_clk or negedge aresetn) begin
      if (!aresetn) begin
         strb_q <= IDLE;
      end else begin
         strb_q <= strb_d;
      end
   end

   strobe_delay #(
      .N (PIPE_DLY),
      .W ($bits(vga_timing_t))
   ) u_dly (
      .clk_i     (pixel_clk),
      .rst_ni    (aresetn),
      .rst_val_i (IDLE),
      .d_i       (strb_q),
      .q_o       (strb_dly)
   );

   logic                fs_q, fs_d;
   logic [BLINK_LOG2:0] fcnt_q, fcnt_d;

   always_comb begin
      fs_d   = (x_q == '0) && (y_q == '0);
      fcnt_d = frame_end ? fcnt_q + 1'b1 : fcnt_q;
   end

   always_ff @(posedge pixel_clk or negedge aresetn) begin
      if (!aresetn) begin
         fs_q   <= 1'b0;
         fcnt_q <= '0;
      end else begin
         fs_q   <= fs_d;
         fcnt_q <= fcnt_d;
      end
   end

   assign drawX       = x_q;
   assign drawY       = y_q;
   assign hsync       = strb_dly.hs;
   assign vsync       = strb_dly.vs;
   assign de          = strb_dly.de;
   assign frame_start = fs_q;
   assign blink       = fcnt_q[BLINK_LOG2];

endmodule

// File: tb/tb_vga_text_timing.sv
// Randomised-reset bench for vga_text_timing against an arithmetic raster model.
// Two instances on a shrunken raster: active-low/2-stage and active-high/0-stage.
module tb_vga_text_timing;

   localparam int unsigned HA = 16, HF = 2, HS = 4, HB = 3;
   localparam int unsigned VA = 8, VF = 1, VS = 2, VB = 2;
   localparam int unsigned HT = HA + HF + HS + HB;
   localparam int unsigned VT = VA + VF + VS + VB;
   localparam int unsigned FR = HT * VT;

   localparam int unsigned PA = 2, BA = 1;
   localparam int unsigned PB = 0, BB = 2;

   logic       clk;
   logic       rst_n;
   logic [9:0] a_x, a_y, b_x, b_y;
   logic       a_hs, a_vs, a_de, a_fs, a_bl;
   logic       b_hs, b_vs, b_de, b_fs, b_bl;

   int unsigned t;
   int          n_chk;
   int          n_err;

   vga_text_timing #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_POL(1'b0), .PIPE_DLY(PA), .BLINK_LOG2(BA)
   ) u_a (
      .pixel_clk   (clk),
      .aresetn     (rst_n),
      .drawX       (a_x),
      .drawY       (a_y),
      .hsync       (a_hs),
      .vsync       (a_vs),
      .de          (a_de),
      .frame_start (a_fs),
      .blink       (a_bl)
   );

   vga_text_timing #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_POL(1'b1), .PIPE_DLY(PB), .BLINK_LOG2(BB)
   ) u_b (
      .pixel_clk   (clk),
      .aresetn     (rst_n),
      .drawX       (b_x),
      .drawY       (b_y),
      .hsync       (b_hs),
      .vsync       (b_vs),
      .de          (b_de),
      .frame_start (b_fs),
      .blink       (b_bl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         if (n_err <= 30)
            $display("FAIL %s t=%0d got %0d want %0d", tag, t, obs, exp);
      end
   endtask

   // t = rising edges since release; raster position is plain division
   function automatic int pos_x(input int unsigned s);
      return int'(s % HT);
   endfunction

   function automatic int pos_y(input int unsigned s);
      return int'((s / HT) % VT);
   endfunction

   function automatic int raw_de(input int unsigned s);
      return (pos_x(s) < HA && pos_y(s) < VA) ? 1 : 0;
   endfunction

   function automatic int raw_hs(input int unsigned s);
      return (pos_x(s) >= HA + HF && pos_x(s) < HA + HF + HS) ? 1 : 0;
   endfunction

   function automatic int raw_vs(input int unsigned s);
      return (pos_y(s) >= VA + VF && pos_y(s) < VA + VF + VS) ? 1 : 0;
   endfunction

   function automatic int exp_de(input int unsigned p);
      return (t < 1 + p) ? 0 : raw_de(t - 1 - p);
   endfunction

   function automatic int exp_sync(input int unsigned p, input int pol,
                                   input int is_h);
      int act;
      if (t < 1 + p) return 1 - pol;
      act = is_h ? raw_hs(t - 1 - p) : raw_vs(t - 1 - p);
      return act ? pol : 1 - pol;
   endfunction

   function automatic int exp_fs();
      return (t >= 1 && ((t - 1) % FR) == 0) ? 1 : 0;
   endfunction

   function automatic int exp_blink(input int unsigned lg);
      return int'(((t / FR) >> lg) & 1);
   endfunction

   task automatic check_all();
      chk("a_drawX", int'(a_x), pos_x(t));
      chk("a_drawY", int'(a_y), pos_y(t));
      chk("a_de", int'(a_de), exp_de(PA));
      chk("a_hsync", int'(a_hs), exp_sync(PA, 0, 1));
      chk("a_vsync", int'(a_vs), exp_sync(PA, 0, 0));
      chk("a_frame_start", int'(a_fs), exp_fs());
      chk("a_blink", int'(a_bl), exp_blink(BA));
      chk("b_drawX", int'(b_x), pos_x(t));
      chk("b_de", int'(b_de), exp_de(PB));
      chk("b_hsync", int'(b_hs), exp_sync(PB, 1, 1));
      chk("b_vsync", int'(b_vs), exp_sync(PB, 1, 0));
      chk("b_frame_start", int'(b_fs), exp_fs());
      chk("b_blink", int'(b_bl), exp_blink(BB));
   endtask

   task automatic check_reset_vals();
      chk("rst_a_drawX", int'(a_x), 0);
      chk("rst_a_drawY", int'(a_y), 0);
      chk("rst_a_de", int'(a_de), 0);
      chk("rst_a_hsync", int'(a_hs), 1);
      chk("rst_a_vsync", int'(a_vs), 1);
      chk("rst_a_fs", int'(a_fs), 0);
      chk("rst_a_blink", int'(a_bl), 0);
      chk("rst_b_hsync", int'(b_hs), 0);
      chk("rst_b_vsync", int'(b_vs), 0);
      chk("rst_b_de", int'(b_de), 0);
      chk("rst_b_blink", int'(b_bl), 0);
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(posedge clk);
         t++;
         @(negedge clk);
         check_all();
      end
   endtask

   // assert mid-cycle, check before the next edge, then release on a negedge
   task automatic do_reset(input int hold);
      #($urandom_range(1, 3));
      rst_n = 1'b0;
      #1;
      check_reset_vals();
      repeat (hold) @(posedge clk);
      @(negedge clk);
      check_reset_vals();
      rst_n = 1'b1;
      t = 0;
      #1;
      check_all();
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      t     = 0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals();
      rst_n = 1'b1;
      #1;
      check_all();
      run(4 * FR + 100);

      do_reset(2);
      run(3 * HT + 10);
      do_reset(1);

      for (int i = 0; i < 6; i++) begin
         run($urandom_range(20, 1200));
         do_reset($urandom_range(1, 4));
      end
      run(FR + 50);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
